// File: rtl/srs_zc_seq.sv
// srs_zc_seq: streaming Zadoff-Chu base-sequence phase generator for SRS (N_ZC >= 31).
//
// Takes the group number u and base sequence number v from the hopping stage.
// A sequential divide-by-31 finds the ZC root q. The block then emits one phase index
// p(m) = q*m*(m+1)/2 mod n_zc per subcarrier, with cyclic extension past n_zc-1.
// The phase is built up by running sums, so the stream path has no multiplier.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle job request, honoured only when idle
//   u, v, n_zc, m_sc   job parameters, latched on an accepted start
//   busy               high whenever a job is in progress
//   done               one-cycle pulse after the last sample (or on a rejected job)
//   err                one-cycle pulse on a rejected job (tied 0 unless checking is built in)
//   out_valid/ready    output stream handshake
//   out_phase          p(m), 0..n_zc-1
//   out_idx            sample index n, 0..m_sc-1
//   out_last           marks the sample with n = m_sc-1
//
// Build option: define SRS_ZC_PARAM_CHK_EN to reject out-of-range jobs at start.

module srs_zc_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  u,
  input  logic        v,
  input  logic [10:0] n_zc,
  input  logic [10:0] m_sc,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_phase,
  output logic [10:0] out_idx,
  output logic        out_last
);

  typedef enum logic [1:0] {StIdle, StQdiv, StQfix, StStream} state_e;

  state_e      state_q;

  // Latched job parameters
  logic        v_q;
  logic [10:0] n_zc_q;
  logic [10:0] m_last_q;   // m_sc - 1, so out_last is a plain equality compare

  // Divider state
  logic [16:0] x_q;        // dividend, shifted out MSB first
  logic [4:0]  rem_q;      // partial remainder, always < 31
  logic [11:0] quo_q;      // quotient bits shifted in LSB side
  logic [4:0]  cnt_q;

  // Stream state
  logic [10:0] q_q;        // ZC root
  logic [10:0] m_q;        // position within the base sequence
  logic [10:0] d_q;        // next phase increment, (m+1)*q mod n_zc
  logic [10:0] p_q;        // current phase
  logic [10:0] n_q;        // current output index
  logic        valid_q;
  logic        last_q;
  logic        done_q;

  // One compare-and-subtract modular add. Both operands are already < n, so the
  // 12-bit sum needs at most one correction.
  function automatic logic [10:0] mod_add(input logic [10:0] a, input logic [10:0] b,
                                          input logic [10:0] n);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, n}) begin
      s = s - {1'b0, n};
    end
    return s[10:0];
  endfunction

  logic [16:0] x_start;
  logic [5:0]  rem_sh;
  logic        rem_ge;
  logic [4:0]  rem_nxt;
  logic [11:0] q0;
  logic [11:0] q0v;
  logic [10:0] q_fix;
  logic        hs;
  logic        wrap;
  logic [10:0] p_nxt;
  logic [10:0] d_nxt;
  logic [10:0] n_nxt;
  logic        job_bad;

  always_comb begin
    // X = 2*n_zc*(u+1); the only multiply, used once per job when latching.
    x_start = 17'({n_zc, 1'b0}) * 17'({1'b0, u} + 6'd1);

    // Restoring divide step by 31
    rem_sh  = {rem_q, x_q[16]};
    rem_ge  = (rem_sh >= 6'd31);
    rem_nxt = rem_ge ? 5'(rem_sh - 6'd31) : rem_sh[4:0];

    // q0 = round-half-up of Q/2, then +v for even Q or -v for odd Q
    q0    = 12'(({1'b0, quo_q} + 13'd1) >> 1);
    q0v   = quo_q[0] ? (q0 - {11'd0, v_q}) : (q0 + {11'd0, v_q});
    // q0v never exceeds n_zc+1 for legal jobs, so one subtract reduces it
    q_fix = 11'((q0v >= {1'b0, n_zc_q}) ? (q0v - {1'b0, n_zc_q}) : q0v);

    hs    = valid_q & out_ready;
    wrap  = (m_q == (n_zc_q - 11'd1));
    p_nxt = mod_add(p_q, d_q, n_zc_q);
    d_nxt = mod_add(d_q, q_q, n_zc_q);
    n_nxt = n_q + 11'd1;
  end

`ifdef SRS_ZC_PARAM_CHK_EN
  logic err_q;

  // m_sc > 2047 cannot be encoded on 11 bits, so only zero needs rejecting
  assign job_bad = (u > 5'd29) || (n_zc < 11'd31) || (n_zc > 11'd2039) || (m_sc == 11'd0);
  assign err     = err_q;
`else
  assign job_bad = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      v_q      <= 1'b0;
      n_zc_q   <= '0;
      m_last_q <= '0;
      x_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      d_q      <= '0;
      p_q      <= '0;
      n_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SRS_ZC_PARAM_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SRS_ZC_PARAM_CHK_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (job_bad) begin
              // Rejected: nothing latched, report and stay idle
              done_q <= 1'b1;
`ifdef SRS_ZC_PARAM_CHK_EN
              err_q  <= 1'b1;
`endif
            end else begin
              v_q      <= v;
              n_zc_q   <= n_zc;
              m_last_q <= m_sc - 11'd1;
              x_q      <= x_start;
              rem_q    <= '0;
              quo_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StQdiv;
            end
          end
        end

        StQdiv: begin
          x_q   <= {x_q[15:0], 1'b0};
          rem_q <= rem_nxt;
          // Legal jobs give Q < 4096, so the bits shifted off the top are zero
          quo_q <= {quo_q[10:0], rem_ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd16) begin
            state_q <= StQfix;
          end
        end

        StQfix: begin
          q_q     <= q_fix;
          d_q     <= q_fix;
          m_q     <= '0;
          p_q     <= '0;
          n_q     <= '0;
          valid_q <= 1'b1;
          last_q  <= (m_last_q == 11'd0);
          state_q <= StStream;
        end

        StStream: begin
          if (hs) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              p_q     <= '0;
              n_q     <= '0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              if (wrap) begin
                // Cyclic extension restarts the base sequence
                m_q <= '0;
                p_q <= '0;
                d_q <= q_q;
              end else begin
                m_q <= m_q + 11'd1;
                p_q <= p_nxt;
                d_q <= d_nxt;
              end
              n_q    <= n_nxt;
              last_q <= (n_nxt == m_last_q);
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_phase = p_q;
  assign out_idx   = n_q;
  assign out_last  = last_q;

endmodule
